// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and index helpers for the window streamer.
// Element offsets count from the MSB end of a flat bus, so element 0 occupies the top DATA_WIDTH bits.
package cnn_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    function automatic int calc_out(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    function automatic int img_off(input int d, input int i, input int j, input int h, input int w);
        return (d * h + i) * w + j;
    endfunction

    function automatic int win_off(input int d, input int i, input int j, input int k);
        return (d * k + i) * k + j;
    endfunction
endpackage

// File: rtl/window_extract.sv
// window_extract: combinational selection of one K x K x D window from a flat image bus.
// Ports: img (D*H*W elements), row/col (window coordinates, scaled by S inside), win (D*K*K elements).
module window_extract import cnn_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int D = 1,
    parameter int H = 34,
    parameter int W = 34,
    parameter int K = 3,
    parameter int S = 1,
    parameter int CW = 6
) (
    input  logic [D*H*W*DATA_WIDTH-1:0] img,
    input  logic [CW-1:0]               row,
    input  logic [CW-1:0]               col,
    output logic [D*K*K*DATA_WIDTH-1:0] win
);
    localparam int NI = D * H * W;
    localparam int NW = D * K * K;

    always_comb begin
        win = '0;
        for (int d = 0; d < D; d++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win[(NW - win_off(d, i, j, K)) * DATA_WIDTH - 1 -: DATA_WIDTH] =
                        img[(NI - img_off(d, int'(row) * S + i, int'(col) * S + j, H, W)) * DATA_WIDTH - 1 -: DATA_WIDTH];
    end
endmodule

// File: rtl/window_streamer.sv
// window_streamer: captures a padded feature map on start and streams every K x K x D window in raster order.
// Ports: start/image_in capture a frame; win_valid/win_ready/win_data/win_last carry windows;
// busy spans the frame, done pulses once after the last accepted window.
// Optional WINDOW_STREAMER_COORD_EN adds win_row/win_col carrying the coordinates of the window on win_data.
module window_streamer import cnn_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int D = 1,
    parameter int H = 34,
    parameter int W = 34,
    parameter int K = 3,
    parameter int S = 1,
    localparam int OH = calc_out(H, K, S),
    localparam int OW = calc_out(W, K, S),
    localparam int CW = $clog2((OH > OW ? OH : OW) + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [D*H*W*DATA_WIDTH-1:0] image_in,
    output logic                        busy,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [D*K*K*DATA_WIDTH-1:0] win_data,
    output logic                        win_last,
    output logic                        done
`ifdef WINDOW_STREAMER_COORD_EN
    ,
    output logic [CW-1:0]               win_row,
    output logic [CW-1:0]               win_col
`endif
);
    localparam logic [CW-1:0] OH1 = CW'(OH - 1);
    localparam logic [CW-1:0] OW1 = CW'(OW - 1);

    state_t state, state_n;
    logic [CW-1:0] r, c, r_n, c_n;
    logic [D*H*W*DATA_WIDTH-1:0] img, img_n;
    logic [D*K*K*DATA_WIDTH-1:0] win_n;
    logic last_n, done_n, fire;

    assign busy      = state == RUN;
    assign win_valid = state == RUN;
    assign fire      = win_valid && win_ready;
`ifdef WINDOW_STREAMER_COORD_EN
    assign win_row = r;
    assign win_col = c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            img      <= '0;
            win_data <= '0;
            win_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            r        <= r_n;
            c        <= c_n;
            img      <= img_n;
            win_data <= win_n;
            win_last <= last_n;
            done     <= done_n;
        end
    end

    // Counters hold on the final window rather than wrapping past the frame.
    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        img_n   = img;
        done_n  = 1'b0;
        if (state == IDLE && start) begin
            state_n = RUN;
            r_n     = '0;
            c_n     = '0;
            img_n   = image_in;
        end else if (fire && win_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end else if (fire) begin
            c_n = c == OW1 ? '0 : c + 1'b1;
            r_n = c == OW1 ? r + 1'b1 : r;
        end
        last_n = state_n == RUN && r_n == OH1 && c_n == OW1;
    end

    // Window is selected from the next-cycle image so window (0,0) is ready the cycle after start.
    window_extract #(
        .DATA_WIDTH(DATA_WIDTH), .D(D), .H(H), .W(W), .K(K), .S(S), .CW(CW)
    ) u_extract (
        .img(img_n),
        .row(r_n),
        .col(c_n),
        .win(win_n)
    );
endmodule

// File: tb/tb_window_streamer.sv
// tb_window_streamer: directed checks of window_streamer across three geometries.
module tb_window_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic         start4 = 0, ready4 = 1, busy4, valid4, last4, done4;
    logic [255:0] img4;
    logic [143:0] data4;
    logic         start5 = 0, ready5 = 1, busy5, valid5, last5, done5;
    logic [399:0] img5;
    logic [143:0] data5;
    logic         start2 = 0, ready2 = 1, busy2, valid2, last2, done2;
    logic [287:0] img2;
    logic [287:0] data2;
`ifdef WINDOW_STREAMER_COORD_EN
    logic [1:0] row4, col4, row5, col5;
    logic [0:0] row2, col2;
`endif

    window_streamer #(.DATA_WIDTH(16), .D(1), .H(4), .W(4), .K(3), .S(1)) u4 (
        .clk(clk), .rst(rst), .start(start4), .image_in(img4), .busy(busy4), .win_valid(valid4),
        .win_ready(ready4), .win_data(data4), .win_last(last4), .done(done4)
`ifdef WINDOW_STREAMER_COORD_EN
        , .win_row(row4), .win_col(col4)
`endif
    );

    window_streamer #(.DATA_WIDTH(16), .D(1), .H(5), .W(5), .K(3), .S(2)) u5 (
        .clk(clk), .rst(rst), .start(start5), .image_in(img5), .busy(busy5), .win_valid(valid5),
        .win_ready(ready5), .win_data(data5), .win_last(last5), .done(done5)
`ifdef WINDOW_STREAMER_COORD_EN
        , .win_row(row5), .win_col(col5)
`endif
    );

    window_streamer #(.DATA_WIDTH(16), .D(2), .H(3), .W(3), .K(3), .S(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .image_in(img2), .busy(busy2), .win_valid(valid2),
        .win_ready(ready2), .win_data(data2), .win_last(last2), .done(done2)
`ifdef WINDOW_STREAMER_COORD_EN
        , .win_row(row2), .win_col(col2)
`endif
    );

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [143:0] w9(input int a, b, c, d, e, f, g, h, i);
        return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h), 16'(i)};
    endfunction

    initial begin
        for (int e = 0; e < 16; e++) img4[(16 - e) * 16 - 1 -: 16] = 16'(e);
        for (int e = 0; e < 25; e++) img5[(25 - e) * 16 - 1 -: 16] = 16'(e);
        for (int e = 0; e < 9; e++) begin
            img2[(18 - e) * 16 - 1 -: 16] = 16'(e);
            img2[(9 - e) * 16 - 1 -: 16]  = 16'(100 + e);
        end
        tick; tick;
        rst = 0;
        chk("rst_busy", busy4, 0);
        chk("rst_valid", valid4, 0);
        chk("rst_data", data4, 0);
        chk("rst_last", last4, 0);
        chk("rst_done", done4, 0);

        start4 = 1; tick; start4 = 0;
        chk("f1_busy", busy4, 1);
        chk("f1_valid", valid4, 1);
        chk("f1_w00", data4, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chk("f1_last00", last4, 0);
        tick;
        chk("f1_w01", data4, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        tick;
        chk("f1_w10", data4, w9(4, 5, 6, 8, 9, 10, 12, 13, 14));
`ifdef WINDOW_STREAMER_COORD_EN
        chk("f1_row10", row4, 1);
        chk("f1_col10", col4, 0);
`endif
        tick;
        chk("f1_w11", data4, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("f1_last11", last4, 1);
        chk("f1_done_pre", done4, 0);
        tick;
        chk("f1_done", done4, 1);
        chk("f1_valid_end", valid4, 0);
        chk("f1_busy_end", busy4, 0);
        start4 = 1; tick; start4 = 0;
        chk("f2_done_clear", done4, 0);
        chk("f2_valid", valid4, 1);
        chk("f2_w00", data4, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        tick;
        ready4 = 0;
        chk("f2_stall1", data4, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        tick;
        chk("f2_stall2", data4, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        img4 = ~img4;
        start4 = 1; tick; start4 = 0;
        chk("f2_stall3", data4, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chk("f2_stall3_valid", valid4, 1);
        chk("f2_stall3_last", last4, 0);
        ready4 = 1; tick;
        chk("f2_w10", data4, w9(4, 5, 6, 8, 9, 10, 12, 13, 14));
        tick;
        chk("f2_w11", data4, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("f2_last", last4, 1);
        tick;
        chk("f2_done", done4, 1);
        tick;
        chk("f2_done_clear2", done4, 0);
        chk("f2_idle", valid4, 0);

        img4 = ~img4;
        start4 = 1; tick; start4 = 0;
        chk("f3_w00", data4, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        tick;
        chk("f3_w01", data4, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        rst = 1; tick; rst = 0;
        chk("rr_valid", valid4, 0);
        chk("rr_busy", busy4, 0);
        chk("rr_done", done4, 0);
        chk("rr_data", data4, 0);
        tick;
        chk("rr_done2", done4, 0);
        start4 = 1; tick; start4 = 0;
        chk("f4_valid", valid4, 1);
        chk("f4_w00", data4, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        tick; tick; tick;
        chk("f4_w11", data4, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        tick;
        chk("f4_done", done4, 1);

        start5 = 1; tick; start5 = 0;
        chk("s2_w00", data5, w9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        tick;
        chk("s2_w02", data5, w9(2, 3, 4, 7, 8, 9, 12, 13, 14));
        tick;
        chk("s2_w20", data5, w9(10, 11, 12, 15, 16, 17, 20, 21, 22));
        chk("s2_last20", last5, 0);
        tick;
        chk("s2_w22", data5, w9(12, 13, 14, 17, 18, 19, 22, 23, 24));
        chk("s2_base", data5[143:128], 12);
        chk("s2_last", last5, 1);
        tick;
        chk("s2_done", done5, 1);
        chk("s2_valid_end", valid5, 0);

        start2 = 1; tick; start2 = 0;
        chk("d2_win", data2, {w9(0, 1, 2, 3, 4, 5, 6, 7, 8), w9(100, 101, 102, 103, 104, 105, 106, 107, 108)});
        chk("d2_last", last2, 1);
        chk("d2_valid", valid2, 1);
        tick;
        chk("d2_done", done2, 1);
        chk("d2_busy_end", busy2, 0);
        tick;
        chk("d2_done_clear", done2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/window_streamer.md
# window_streamer

Stage directly downstream of the zero-padding stage, feeding the convolution engine. It captures one padded feature map, presented as a flat bus, on a start pulse. It then streams every K×K×D receptive-field window in raster order, one window per accepted transfer, over a valid/ready handshake. This lets the convolution stage consume one window per cycle instead of indexing the whole image.

## Interface
- DATA_WIDTH, 16, bits per element
- D, 1, channel depth
- H, 34, padded input height
- W, 34, padded input width
- K, 3, window size (K×K)
- S, 1, stride
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to capture image_in and begin streaming
- image_in  in  D*H*W*DATA_WIDTH  padded image; element (d,i,j) at bit offset (d*H*W + i*W + j)*DATA_WIDTH, bit 0 = MSB side
- busy  out  1  high from capture until the last window is accepted
- win_valid  out  1  win_data holds a valid window
- win_ready  in  1  consumer accepts the window this cycle
- win_data  out  D*K*K*DATA_WIDTH  window; element (d,ki,kj) at offset (d*K*K + ki*K + kj)*DATA_WIDTH
- win_last  out  1  current window is the final one (row OH-1, col OW-1)
- done  out  1  one-cycle pulse after the last window is accepted
- win_row, win_col  out  $clog2(OH+1) each  output coordinates; present only with WINDOW_STREAMER_COORD_EN

## Operation
- OH = (H-K)/S + 1 and OW = (W-K)/S + 1, integer floor. Trailing rows/columns that do not fill a window are dropped.
- Window (r,c) covers input rows r*S..r*S+K-1 and columns c*S..c*S+K-1, across all D channels.
- Two states:
  - IDLE: start=1 latches image_in into the internal image register, sets r=c=0, and moves to RUN.
  - RUN: on win_valid && win_ready, advance c. If c = OW-1, set c=0 and increment r. If the transfer was win_last, return to IDLE.
- start in RUN is ignored; the image register is not updated.
- image_in is sampled only in the start cycle. It may change afterwards.
- Each element is copied bit-exact. No arithmetic on data.
- Counters saturate logically at OH-1/OW-1; no wrap past last.

## Timing
- Reset values: busy=0, win_valid=0, win_data=0, win_last=0, done=0, win_row=win_col=0, state=IDLE. The image register is cleared.
- Start cycle N: busy=1 and win_valid=1 from cycle N+1, with window (0,0) on win_data.
- All outputs are registered. After an accepted transfer in cycle M, the next window appears in cycle M+1, so throughput is one window per cycle when win_ready is held high.
- While win_valid && !win_ready, win_data, win_last and the coordinates hold stable.
- Last window accepted in cycle L: win_valid=0, busy=0 and done=1 in L+1; done=0 in L+2.
- start in the same cycle as done=1 is accepted (state is already IDLE), giving back-to-back frames.
- rst during RUN: all outputs return to reset values on the next edge. The in-flight frame is discarded and no done pulse is issued.
- Total frame latency with win_ready held high: OH*OW + 1 cycles from start to done.

## Configuration
- WINDOW_STREAMER_COORD_EN defined: win_row/win_col ports exist and carry the r/c of the window currently on win_data, updating together with it.
- Not defined: the ports are absent. r/c remain internal only and behaviour is otherwise identical.

## Structure
- Shared package cnn_pkg holds:
  - element index functions (flat image offset, window offset)
  - OH/OW computation functions
  - state enum {IDLE, RUN}
- One combinational sub-module, window_extract, selects the K×K×D slice from the image register given base row/col. window_streamer registers its output.

## Test plan
- D=1, H=W=4, K=3, S=1, element (i,j) = 4i+j, win_ready=1. Required: 4 windows in consecutive cycles.
  - (0,0) = {0,1,2,4,5,6,8,9,10}
  - (1,1) = {5,6,7,9,10,11,13,14,15} with win_last=1
  - done exactly one cycle later
- Same image with win_ready low for 3 cycles on window (0,1). Required: win_data = {1,2,3,5,6,7,9,10,11} stable all 3 cycles; no window skipped.
- H=W=5, K=3, S=2. Required: windows at (0,0), (0,2), (2,0), (2,2) only; (2,2) base element is 12.
- D=2, H=W=3, K=3, S=1, channel-1 elements = 100 + index. Required: a single window, win_last=1, channel-0 elements first, then 100..108.
- start pulsed again during RUN with a different image_in. Required: the stream continues with the original image and no restart. A start coincident with done launches a new frame starting in the next cycle.
- rst asserted after the second window. Required: win_valid=0, busy=0 next cycle, no done pulse. A subsequent start restarts from (0,0).
